e1_tx_phy_mc: RTL and testbench

E1_TX_PHY_MC -- requirements
Module: e1_tx_phy_mc

---
 rtl/e1_defs.sv | 22 ++
 rtl/e1_tx_phy_ch.sv | 90 +++++++++
 rtl/e1_tx_phy_io.sv | 33 +++
 rtl/e1_tx_phy_mc.sv | 63 ++++++
 tb/tb_e1_tx_phy_mc.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/e1_defs.sv
// Shared constants for the E1 TX PHY: pulse state encodings and counter sizing.
// Optional build macro: E1_TX_PHY_TRISTATE_EN (pads tristated while disabled).
package e1_defs;

  localparam int CNT_W       = 4;
  localparam int PULSE_W_MIN = 1;
  localparam int PULSE_W_MAX = (1 << CNT_W) - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MARK_P = 2'd1,
    MARK_N = 2'd2
  } pulse_st_t;

  // Out-of-range widths saturate rather than wrapping the counter.
  function automatic logic [CNT_W-1:0] pulse_load(input int w);
    if (w < PULSE_W_MIN) return CNT_W'(PULSE_W_MIN);
    if (w > PULSE_W_MAX) return CNT_W'(PULSE_W_MAX);
    return CNT_W'(w);
  endfunction

endpackage

// File: rtl/e1_tx_phy_ch.sv
// One E1 TX channel: HDB3 symbol to RZ mark pulse generator with sticky errors.
// Stage 1 of the pad path; the pad register lives in e1_tx_phy_io.
module e1_tx_phy_ch
  import e1_defs::*;
#(
  parameter int PULSE_W = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic ch_en,
  input  logic tx_stb,
  input  logic tx_hi,
  input  logic tx_lo,
  input  logic err_clr,
  output logic mark_hi,
  output logic mark_lo,
  output logic err_conflict,
  output logic err_overrun
);

  localparam logic [CNT_W-1:0] LOAD = pulse_load(PULSE_W);

  pulse_st_t        state;
  pulse_st_t        state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             conf_set;
  logic             ovr_set;
  logic             sym_p;
  logic             sym_n;
  logic             sym_x;

  assign sym_p = tx_hi & ~tx_lo;
  assign sym_n = tx_lo & ~tx_hi;
  assign sym_x = tx_hi & tx_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    conf_set = 1'b0;
    ovr_set  = 1'b0;
    if (!ch_en) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        MARK_P, MARK_N: begin
          cnt_n = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_n = IDLE;
        end
        default: ;
      endcase
      // A new mark always wins over the running pulse.
      if (tx_stb) begin
        conf_set = sym_x;
        if (sym_p || sym_n) begin
          state_n = sym_p ? MARK_P : MARK_N;
          cnt_n   = LOAD;
          ovr_set = (cnt != '0);
        end
      end
    end
  end

  assign mark_hi = (state == MARK_P);
  assign mark_lo = (state == MARK_N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_conflict <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      if (conf_set)     err_conflict <= 1'b1;
      else if (err_clr) err_conflict <= 1'b0;
      if (ovr_set)      err_overrun  <= 1'b1;
      else if (err_clr) err_overrun  <= 1'b0;
    end
  end

endmodule

// File: rtl/e1_tx_phy_io.sv
// Registered output pad cell (iCE40 SB_IO registered-output equivalent).
// With E1_TX_PHY_TRISTATE_EN the output enable is registered as well.
module e1_tx_phy_io (
  input  logic clk,
  input  logic rst,
  input  logic d,
`ifdef E1_TX_PHY_TRISTATE_EN
  input  logic oe,
`endif
  output logic pad
);

  logic q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

`ifdef E1_TX_PHY_TRISTATE_EN
  logic oe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) oe_q <= 1'b0;
    else     oe_q <= oe;
  end

  assign pad = oe_q ? q : 1'bz;
`else
  assign pad = q;
`endif

endmodule

// File: rtl/e1_tx_phy_mc.sv
// Multi-channel E1 TX PHY: N_CH pulse generators feeding registered pads.
// Build macro E1_TX_PHY_TRISTATE_EN tristates pads of disabled channels.
module e1_tx_phy_mc
  import e1_defs::*;
#(
  parameter int N_CH    = 1,
  parameter int PULSE_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] tx_hi,
  input  logic [N_CH-1:0] tx_lo,
  input  logic [N_CH-1:0] tx_stb,
  input  logic [N_CH-1:0] ch_en,
  input  logic [N_CH-1:0] err_clr,
  output logic [N_CH-1:0] pad_tx_hi,
  output logic [N_CH-1:0] pad_tx_lo,
  output logic [N_CH-1:0] err_conflict,
  output logic [N_CH-1:0] err_overrun
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic mark_hi;
    logic mark_lo;

    e1_tx_phy_ch #(
      .PULSE_W (PULSE_W)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .ch_en        (ch_en[i]),
      .tx_stb       (tx_stb[i]),
      .tx_hi        (tx_hi[i]),
      .tx_lo        (tx_lo[i]),
      .err_clr      (err_clr[i]),
      .mark_hi      (mark_hi),
      .mark_lo      (mark_lo),
      .err_conflict (err_conflict[i]),
      .err_overrun  (err_overrun[i])
    );

    e1_tx_phy_io u_io_hi (
      .clk (clk),
      .rst (rst),
      .d   (mark_hi),
`ifdef E1_TX_PHY_TRISTATE_EN
      .oe  (ch_en[i]),
`endif
      .pad (pad_tx_hi[i])
    );

    e1_tx_phy_io u_io_lo (
      .clk (clk),
      .rst (rst),
      .d   (mark_lo),
`ifdef E1_TX_PHY_TRISTATE_EN
      .oe  (ch_en[i]),
`endif
      .pad (pad_tx_lo[i])
    );
  end

endmodule

// File: tb/tb_e1_tx_phy_mc.sv
// Bench for e1_tx_phy_mc: vector table for error flags, pulse scoreboard
// per channel, plus sequences for overrun, disable and reset corner cases.
module tb_e1_tx_phy_mc;

  localparam int NC = 4;
  localparam int W  = 7;

`ifdef E1_TX_PHY_TRISTATE_EN
  localparam logic OFF = 1'bz;
`else
  localparam logic OFF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] tx_hi;
  logic [NC-1:0] tx_lo;
  logic [NC-1:0] tx_stb;
  logic [NC-1:0] ch_en;
  logic [NC-1:0] err_clr;
  wire  [NC-1:0] pad_tx_hi;
  wire  [NC-1:0] pad_tx_lo;
  wire  [NC-1:0] err_conflict;
  wire  [NC-1:0] err_overrun;

  e1_tx_phy_mc #(
    .N_CH    (NC),
    .PULSE_W (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_hi        (tx_hi),
    .tx_lo        (tx_lo),
    .tx_stb       (tx_stb),
    .ch_en        (ch_en),
    .err_clr      (err_clr),
    .pad_tx_hi    (pad_tx_hi),
    .pad_tx_lo    (pad_tx_lo),
    .err_conflict (err_conflict),
    .err_overrun  (err_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  typedef struct {
    logic pol;
    int   start;
    int   len;
  } pulse_t;

  pulse_t exp_q [NC][$];

  task automatic push(input int c, input logic pol, input int start,
                      input int len);
    pulse_t e;
    e.pol   = pol;
    e.start = start;
    e.len   = len;
    exp_q[c].push_back(e);
  endtask

  // Pulse monitor: measures every run on every pad and pops the scoreboard.
  bit     run [NC][2];
  int     st  [NC][2];
  int     overlap = 0;

  always @(negedge clk) begin
    logic   cur;
    pulse_t e;
    for (int c = 0; c < NC; c++) begin
      if (pad_tx_hi[c] === 1'b1 && pad_tx_lo[c] === 1'b1) overlap++;
      for (int p = 0; p < 2; p++) begin
        cur = (p == 0) ? (pad_tx_hi[c] === 1'b1) : (pad_tx_lo[c] === 1'b1);
        if (cur && !run[c][p]) begin
          run[c][p] = 1'b1;
          st[c][p]  = cyc;
        end else if (!cur && run[c][p]) begin
          run[c][p] = 1'b0;
          if (exp_q[c].size() == 0) begin
            n_chk++;
            $display("FAIL pulse_ch%0d: got unexpected pol %0d start %0d len %0d want none",
                     c, p, st[c][p], cyc - st[c][p]);
          end else begin
            e = exp_q[c].pop_front();
            check($sformatf("pulse_ch%0d_pol", c), 32'(p), 32'(e.pol));
            check($sformatf("pulse_ch%0d_start", c), 32'(st[c][p]), 32'(e.start));
            check($sformatf("pulse_ch%0d_len", c), 32'(cyc - st[c][p]), 32'(e.len));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NC-1:0] stb, input logic [NC-1:0] hi,
                       input logic [NC-1:0] lo, input logic [NC-1:0] clr,
                       input bit model);
    tx_stb  = stb;
    tx_hi   = hi;
    tx_lo   = lo;
    err_clr = clr;
    for (int c = 0; c < NC; c++)
      if (model && stb[c] && ch_en[c] && (hi[c] ^ lo[c]))
        push(c, lo[c], cyc + 2, W);
    tick();
    tx_stb  = '0;
    tx_hi   = '0;
    tx_lo   = '0;
    err_clr = '0;
  endtask

  task automatic chk_err(input string name, input logic [NC-1:0] c,
                         input logic [NC-1:0] o);
    check({name, "_conflict"}, 32'(err_conflict), 32'(c));
    check({name, "_overrun"}, 32'(err_overrun), 32'(o));
  endtask

  typedef struct {
    logic [NC-1:0] stb;
    logic [NC-1:0] hi;
    logic [NC-1:0] lo;
    logic [NC-1:0] clr;
    int            gap;
    logic [NC-1:0] conf;
    logic [NC-1:0] ovr;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int n;
    vecs[0] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 12, 4'b0000, 4'b0000};
    vecs[1] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 12, 4'b0000, 4'b0000};
    vecs[2] = '{4'b1111, 4'b0101, 4'b1010, 4'b0000, 12, 4'b0000, 4'b0000};
    vecs[3] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 12, 4'b0000, 4'b0000};
    vecs[4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 12, 4'b0010, 4'b0000};
    vecs[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 12, 4'b0000, 4'b0000};
    vecs[6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 12, 4'b0100, 4'b0000};
    vecs[7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 12, 4'b0100, 4'b0000};
    vecs[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 12, 4'b0000, 4'b0000};
    vecs[9] = '{4'b1000, 4'b1001, 4'b0000, 4'b0000, 12, 4'b0000, 4'b0000};

    rst = 1'b1; tx_hi = '0; tx_lo = '0; tx_stb = '0;
    err_clr = '0; ch_en = '1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pad_hi", 32'(pad_tx_hi), 32'({NC{OFF}}));
    check("reset_pad_lo", 32'(pad_tx_lo), 32'({NC{OFF}}));
    chk_err("reset", 4'b0000, 4'b0000);
    rst = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].stb, vecs[i].hi, vecs[i].lo, vecs[i].clr, 1'b1);
      repeat (vecs[i].gap) tick();
      chk_err($sformatf("vec%0d", i), vecs[i].conf, vecs[i].ovr);
    end

    // 32 alternating marks on channel 0, one every 15 cycles
    for (int b = 0; b < 32; b++) begin
      drive(4'b0001, (b % 2 == 0) ? 4'b0001 : 4'b0000,
            (b % 2 == 0) ? 4'b0000 : 4'b0001, 4'b0000, 1'b1);
      repeat (14) tick();
    end
    chk_err("alternate", 4'b0000, 4'b0000);

    // overrun with polarity change on channel 1
    n = cyc;
    push(1, 1'b0, n + 2, 3);
    push(1, 1'b1, n + 5, W);
    drive(4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    repeat (2) tick();
    drive(4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    repeat (12) tick();
    chk_err("overrun_flip", 4'b0000, 4'b0010);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    chk_err("overrun_clr", 4'b0000, 4'b0000);

    // same-polarity overrun stretches the pulse
    n = cyc;
    push(1, 1'b0, n + 2, 10);
    drive(4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    repeat (2) tick();
    drive(4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    repeat (14) tick();
    chk_err("overrun_same", 4'b0000, 4'b0010);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    tick();

    // disable channel 2 mid-pulse, then strobe it while disabled
    n = cyc;
    push(2, 1'b0, n + 2, 3);
    drive(4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    repeat (2) tick();
    ch_en = 4'b1011;
    repeat (10) tick();
    drive(4'b0100, 4'b0100, 4'b0100, 4'b0000, 1'b1);
    drive(4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    repeat (10) tick();
    chk_err("disabled", 4'b0000, 4'b0000);
    ch_en = 4'b1111;
    repeat (3) tick();

    // reset during a pulse clears pads and flags at once
    drive(4'b1000, 4'b1000, 4'b1000, 4'b0000, 1'b1);
    tick();
    chk_err("pre_reset", 4'b1000, 4'b0000);
    n = cyc;
    push(0, 1'b0, n + 2, 4);
    drive(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("midrst_pad_hi", 32'(pad_tx_hi), 32'({NC{OFF}}));
    check("midrst_pad_lo", 32'(pad_tx_lo), 32'({NC{OFF}}));
    chk_err("midrst", 4'b0000, 4'b0000);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    drive(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    repeat (12) tick();

    // only enabled channels 1 and 3 respond
    ch_en = 4'b1010;
    repeat (3) tick();
    drive(4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b1);
    repeat (3) tick();
    check("en_mask_hi", 32'(pad_tx_hi), 32'({1'b1, OFF, 1'b1, OFF}));
    check("en_mask_lo", 32'(pad_tx_lo), 32'({1'b0, OFF, 1'b0, OFF}));
    repeat (10) tick();
    chk_err("en_mask", 4'b0000, 4'b0000);
    ch_en = 4'b1111;
    repeat (10) tick();

    for (int c = 0; c < NC; c++)
      check($sformatf("pending_ch%0d", c), 32'(exp_q[c].size()), 32'd0);
    check("overlap_cycles", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
